// File: rtl/ifetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, instr} fed from a ROM, with redirect flush. Optional macro: IFQ_BYPASS_EN.
// Latency: fetch to inst_valid is 1 cycle when empty (0 cycles with IFQ_BYPASS_EN).
// Backpressure: inst_ready=0 holds the head; fetching stalls when full unless a pop frees a slot the same cycle.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        en_fetch,
    output logic [31:0] PC,
    input  logic [31:0] instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [3:0]  count
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_pc;
    logic [3:0]      r_count;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [31:0]     r_mem_pc  [DEPTH];
    logic [31:0]     r_mem_ins [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_fetch_ok;
    logic            w_pop_q;
    logic            w_bypass;
    logic            w_write;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            S_FLUSH: w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect) w_state_nxt = S_FLUSH;
    end

    always_comb begin
        w_empty    = (r_count == 4'd0);
        w_full     = (r_count == DEPTH_C);
        w_fetch_ok = (r_state == S_RUN) && !redirect && !rst;
        // w_pop_q covers stored entries only; a bypassed entry never reaches the array
        w_pop_q    = !w_empty && !redirect && !rst && inst_ready;
        en_fetch   = w_fetch_ok && (!w_full || w_pop_q);
`ifdef IFQ_BYPASS_EN
        w_bypass   = en_fetch && w_empty;
`else
        w_bypass   = 1'b0;
`endif
        w_write    = en_fetch && !(w_bypass && inst_ready);
        inst_valid = (!w_empty && !redirect && !rst) || w_bypass;
        if (w_bypass) begin
            inst_out = instruction;
            inst_pc  = r_pc;
        end else if (rst || w_empty) begin
            inst_out = 32'h0;
            inst_pc  = 32'h0;
        end else begin
            inst_out = r_mem_ins[r_head];
            inst_pc  = r_mem_pc[r_head];
        end
        PC    = rst ? RESET_PC : r_pc;
        count = rst ? 4'd0 : r_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_count <= 4'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect) begin
                r_pc    <= redirect_pc;
                r_count <= 4'd0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (en_fetch) r_pc   <= r_pc + 32'd4;
                if (w_write)  r_tail <= f_inc(r_tail);
                if (w_pop_q)  r_head <= f_inc(r_head);
                r_count <= r_count + {3'b000, w_write} - {3'b000, w_pop_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_pc[r_tail]  <= r_pc;
            r_mem_ins[r_tail] <= instruction;
        end
    end

endmodule
